fifo_ctrl_responder: RTL and testbench



---
 rtl/fifo_ctrl_responder.sv | 112 +++++++++++
 tb/tb_fifo_ctrl_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_responder.sv
// Fabric-side peer of the CPU FIFO-control PIO bus: synchronised commands, sample FIFO, status lines.
// Define FIFO_CTRL_OVF_EN to build the sticky overflow flag on ctrl_port[4]; otherwise that line is Z.
module fifo_ctrl_responder #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [4:0]            ctrl_port,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = LVL_W'(DEPTH);

  // sample_valid carries no back-pressure: in the cycle it is high the sample
  // is either written or dropped, never held for a later cycle.

  logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  pop_prev_q, pop_prev_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                  empty_q, empty_d;
  logic                  rst_s, cap_s, pop_s;
  logic                  full, wr_try, wr_en, pop_en;
  logic [DATA_W-1:0]     mem [DEPTH];

  always_comb begin
    sync1_d    = ctrl_port[2:0];
    sync2_d    = sync1_q;
    rst_s      = sync2_q[0];
    cap_s      = sync2_q[1];
    pop_s      = sync2_q[2];
    pop_prev_d = pop_s;

    // Full/empty come from the level so a simultaneous write sees the pre-pop occupancy.
    full   = (level_q == LVL_FULL);
    wr_try = sample_valid && cap_s && !rst_s;
    wr_en  = wr_try && !full;
    pop_en = (pop_s != pop_prev_q) && !rst_s && (level_q != '0);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (rst_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_en) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      level_d = level_q + LVL_W'(wr_en) - LVL_W'(pop_en);
    end

    rd_data_d = rst_s ? '0 : mem[rd_ptr_q];
    empty_d   = (level_q == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      pop_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      empty_q    <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      pop_prev_q <= pop_prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      empty_q    <= empty_d;
    end
  end

`ifdef FIFO_CTRL_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = rst_s ? 1'b0 : (ovf_q || (wr_try && full));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ctrl_port[4] = ovf_q;
`else
  assign ctrl_port[4] = 1'bz;
`endif

  // Bits 2:0 belong to the CPU and are deliberately left undriven here.
  assign ctrl_port[3] = empty_q;
  assign rd_data      = rd_data_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_fifo_ctrl_responder.sv
// Self-checking bench for fifo_ctrl_responder: directed command sequence with random sample data
// checked against a queue model of the FIFO contents, occupancy and overflow flag.
module tb_fifo_ctrl_responder;

  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                reset;
  wire  [4:0]          ctrl_port;
  logic [2:0]          cmd;
  logic [DATA_W-1:0]   sample_in;
  logic                sample_valid;
  logic [DATA_W-1:0]   rd_data;
  logic [DEPTH_LOG2:0] fifo_level;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents in order, sticky overflow, and the CPU's settled command view.
  logic [DATA_W-1:0] exp_q[$];
  bit model_ovf;
  bit model_rst;
  bit model_cap;

  assign ctrl_port[2:0] = cmd;

  fifo_ctrl_responder #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl_port    (ctrl_port),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .rd_data      (rd_data),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input bit r, input bit c);
    cmd[0] = r;
    cmd[1] = c;
    step(4);
    model_rst = r;
    model_cap = c;
    if (r) begin
      exp_q.delete();
      model_ovf = 1'b0;
    end
  endtask

  task automatic write_sample(input logic [DATA_W-1:0] d);
    sample_in    = d;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    if (model_cap && !model_rst) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                      model_ovf = 1'b1;
    end
  endtask

  task automatic pop_toggle();
    cmd[2] = ~cmd[2];
    step(4);
    if (!model_rst && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic check_ovf(input string tag);
`ifdef FIFO_CTRL_OVF_EN
    chk({tag, "_ovf"}, 32'(ctrl_port[4]), 32'(model_ovf));
`else
    chk({tag, "_ovf_off"}, 32'(ctrl_port[4] === 1'b1), 32'd0);
`endif
  endtask

  task automatic check_state(input string tag);
    step(1);
    chk({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
    chk({tag, "_empty"}, 32'(ctrl_port[3]), 32'(exp_q.size() == 0));
    if (model_rst)            chk({tag, "_rdz"}, 32'(rd_data), 32'd0);
    else if (exp_q.size() > 0) chk({tag, "_rd"}, 32'(rd_data), 32'(exp_q[0]));
    check_ovf(tag);
  endtask

  initial begin
    reset        = 1'b1;
    cmd          = 3'b000;
    sample_in    = '0;
    sample_valid = 1'b0;
    model_ovf    = 1'b0;
    model_rst    = 1'b0;
    model_cap    = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_empty", 32'(ctrl_port[3]), 32'd1);
    chk("reset_rd",    32'(rd_data), 32'd0);
    check_ovf("reset");

    // Samples are ignored until capture is enabled.
    write_sample(16'h5555);
    check_state("cap_off");

    set_cmd(1'b0, 1'b1);

    // First write: level moves on the write edge, empty/rd_data one edge later.
    sample_in    = 16'h0001;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    exp_q.push_back(16'h0001);
    chk("first_wr_level", 32'(fifo_level), 32'd1);
    chk("first_wr_empty_lag", 32'(ctrl_port[3]), 32'd1);
    step(1);
    chk("first_wr_empty", 32'(ctrl_port[3]), 32'd0);
    chk("first_wr_rd", 32'(rd_data), 32'h0001);
    write_sample(16'h0002);
    write_sample(16'h0003);
    check_state("three_words");

    // Pop timing: two synchroniser stages, then the update edge, then the read edge.
    cmd[2] = ~cmd[2];
    step(2);
    chk("pop_not_yet", 32'(fifo_level), 32'd3);
    step(1);
    chk("pop_level", 32'(fifo_level), 32'd2);
    step(1);
    chk("pop_rd", 32'(rd_data), 32'h0002);
    void'(exp_q.pop_front());
    pop_toggle();
    check_state("pop2");
    chk("pop2_rd3", 32'(rd_data), 32'h0003);
    pop_toggle();
    check_state("pop3");

    // Random mix of writes and pops at small occupancy.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 6) write_sample(DATA_W'($urandom));
      else                          pop_toggle();
      check_state("rand");
    end

    // Soft reset clears contents and blocks writes while held.
    set_cmd(1'b1, 1'b1);
    check_state("soft_rst");
    write_sample(16'h7777);
    check_state("soft_rst_blocked");
    set_cmd(1'b0, 1'b1);

    // Fill to capacity, then one extra sample that must be dropped.
    for (int i = 0; i < DEPTH; i++) write_sample(DATA_W'($urandom));
    check_state("full");
    write_sample(16'hBEEF);
    check_state("overfill");
    set_cmd(1'b1, 1'b1);
    check_state("ovf_clear");
    set_cmd(1'b0, 1'b1);

    // Full FIFO with pop and write on the same edge: pop wins, write is dropped.
    for (int i = 0; i < DEPTH; i++) write_sample(DATA_W'($urandom));
    check_state("refull");
    cmd[2] = ~cmd[2];
    step(2);
    sample_in    = 16'hDEAD;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    void'(exp_q.pop_front());
    model_ovf = 1'b1;
    check_state("full_pop_wr");

    // Drain in order, checking every head word.
    for (int i = 0; i < DEPTH - 1; i++) begin
      pop_toggle();
      check_state("drain");
    end
    chk("drained_level", 32'(fifo_level), 32'd0);

    // A pop at level 0 is forgotten.
    pop_toggle();
    write_sample(16'h00AA);
    check_state("stale_pop");
    chk("stale_pop_rd", 32'(rd_data), 32'h00AA);
    chk("stale_pop_lvl", 32'(fifo_level), 32'd1);
    pop_toggle();
    check_state("empty_again");

    // Empty FIFO with pop and write on the same edge: write lands, pop ignored.
    cmd[2] = ~cmd[2];
    step(2);
    sample_in    = 16'h0BB0;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    exp_q.push_back(16'h0BB0);
    check_state("empty_pop_wr");

    // Hard reset mid-capture with the pop line high: immediate clear, no phantom pop.
    for (int i = 0; i < 5; i++) write_sample(DATA_W'($urandom));
    if (!cmd[2]) pop_toggle();
    check_state("pre_reset");
    reset = 1'b1;
    #1;
    chk("async_level", 32'(fifo_level), 32'd0);
    chk("async_empty", 32'(ctrl_port[3]), 32'd1);
    chk("async_rd",    32'(rd_data), 32'd0);
    exp_q.delete();
    model_ovf = 1'b0;
    step(2);
    reset = 1'b0;
    step(4);
    check_state("post_reset");
    write_sample(16'h1234);
    check_state("post_reset_wr");
    step(4);
    check_state("post_reset_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
